dds_wave_generator: RTL

Parametrised direct-digital-synthesis waveform source, the successor to the fixed 256-entry, step-by-one sine counter. A phase accumulator advances by a programmable tuning word, giving a fractional frequency step. A quarter-wave sine ROM, folded by quadrant symmetry, plus square, sawtooth and triangle modes feed a 3-stage registered output pipeline. It sits in front of the DAC/PWM path and any block that needs a test tone.

---
 rtl/dds_wave_generator.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dds_wave_generator.sv
// dds_wave_generator
//   Direct-digital-synthesis waveform source. A phase accumulator advances
//   by a programmable tuning word. Its top LUT_AW bits, plus a phase offset,
//   form a table index. That index drives one of four waveforms through a
//   3-stage registered pipeline. The sine is built from a quarter-wave ROM
//   that is folded by quadrant symmetry.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   enable       1 = accumulator advances by tune_reg this cycle
//   tune_load    1 = capture tune_word into tune_reg
//   tune_word    phase increment per enabled cycle (PHASE_W bits)
//   phase_offset added to the table index, modulo N (LUT_AW bits)
//   mode         0 sine, 1 square, 2 sawtooth, 3 triangle
//   sync         1 = clear accumulator (phase restart); wins over enable
//   wave_out     offset-binary sample (OUT_W bits)
//   wave_valid   wave_out came from a cycle in which enable was high
//   wrap         one-cycle pulse on accumulator carry-out
module dds_wave_generator #(
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 8,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               tune_load,
  input  logic [PHASE_W-1:0] tune_word,
  input  logic [LUT_AW-1:0]  phase_offset,
  input  logic [1:0]         mode,
  input  logic               sync,
  output logic [OUT_W-1:0]   wave_out,
  output logic               wave_valid,
  output logic               wrap
);

  localparam int N   = 2 ** LUT_AW;
  localparam int QN  = N / 4;
  localparam int QAW = LUT_AW - 2;
  localparam logic [OUT_W-1:0] MID    = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] MID_M1 = {1'b0, {(OUT_W-1){1'b1}}};

  // Quarter-wave amplitude for entry j, evaluated at elaboration only.
  // sin() comes from a Taylor series, because the argument never exceeds
  // pi/2 and that keeps the function to plain real arithmetic. Sampling
  // at j+0.5 makes the folded quadrants meet without a repeated point.
  function automatic int sine_q(input int j);
    real x;
    real term;
    real s;
    real amp;
    x    = 2.0 * 3.14159265358979323846 * (real'(j) + 0.5) / real'(N);
    term = x;
    s    = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      s    = s + term;
    end
    amp = real'((2 ** (OUT_W - 1)) - 1);
    return $rtoi(amp * s + 0.5);
  endfunction

  logic [OUT_W-2:0] rom [QN];

  for (genvar gi = 0; gi < QN; gi++) begin : g_rom
    localparam int QV = sine_q(gi);
    assign rom[gi] = QV[OUT_W-2:0];
  end

  // Accumulator and tuning register
  logic [PHASE_W-1:0] acc_reg;
  logic [PHASE_W-1:0] tune_reg;
  logic               wrap_reg;
  logic [PHASE_W:0]   sum_next;

  assign sum_next = {1'b0, acc_reg} + {1'b0, tune_reg};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg  <= '0;
      tune_reg <= '0;
      wrap_reg <= 1'b0;
    end else begin
      // A tune loaded in this cycle is first used by the next accumulate.
      if (tune_load) tune_reg <= tune_word;
      if (sync) begin
        acc_reg  <= '0;
        wrap_reg <= 1'b0;
      end else if (enable) begin
        acc_reg  <= sum_next[PHASE_W-1:0];
        wrap_reg <= sum_next[PHASE_W];
      end else begin
        wrap_reg <= 1'b0;
      end
    end
  end

  // Stage 1: table index, with mode and valid sampled alongside it
  logic [LUT_AW-1:0] idx1_reg;
  logic [1:0]        mode1_reg;
  logic              v1_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx1_reg  <= '0;
      mode1_reg <= '0;
      v1_reg    <= 1'b0;
    end else begin
      idx1_reg  <= acc_reg[PHASE_W-1 -: LUT_AW] + phase_offset;
      mode1_reg <= mode;
      v1_reg    <= enable;
    end
  end

  // Stage 2: quadrant fold and registered ROM read
  logic [1:0]        q1;
  logic [QAW-1:0]    j1;
  logic [QAW-1:0]    rom_addr;
  logic [OUT_W-2:0]  rom_q_reg;
  logic [1:0]        q2_reg;
  logic [1:0]        mode2_reg;
  logic [LUT_AW-1:0] idx2_reg;
  logic              v2_reg;

  assign q1 = idx1_reg[LUT_AW-1 -: 2];
  assign j1 = idx1_reg[QAW-1:0];
  // Odd quadrants run the quarter table backwards: N/4-1-j is ~j.
  assign rom_addr = q1[0] ? ~j1 : j1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_q_reg <= '0;
      q2_reg    <= '0;
      mode2_reg <= '0;
      idx2_reg  <= '0;
      v2_reg    <= 1'b0;
    end else begin
      rom_q_reg <= rom[rom_addr];
      q2_reg    <= q1;
      mode2_reg <= mode1_reg;
      idx2_reg  <= idx1_reg;
      v2_reg    <= v1_reg;
    end
  end

  // Stage 3: waveform select
  logic [LUT_AW-2:0] tri_t;
  logic [LUT_AW-1:0] tri_full;
  logic [OUT_W-1:0]  saw_val;
  logic [OUT_W-1:0]  tri_val;
  logic [OUT_W-1:0]  wave_next;
  logic [OUT_W-1:0]  wave_reg;
  logic              v3_reg;

  assign tri_t    = idx2_reg[LUT_AW-1] ? ~idx2_reg[LUT_AW-2:0] : idx2_reg[LUT_AW-2:0];
  assign tri_full = {tri_t, 1'b0};

  // Left-justify the LUT_AW-bit ramps into OUT_W bits.
  if (OUT_W >= LUT_AW) begin : g_pad
    assign saw_val = OUT_W'(idx2_reg) << (OUT_W - LUT_AW);
    assign tri_val = OUT_W'(tri_full) << (OUT_W - LUT_AW);
  end else begin : g_trunc
    assign saw_val = OUT_W'(idx2_reg >> (LUT_AW - OUT_W));
    assign tri_val = OUT_W'(tri_full >> (LUT_AW - OUT_W));
  end

  always_comb begin
    wave_next = '0;
    case (mode2_reg)
      2'd0:    wave_next = q2_reg[1] ? (MID_M1 - {1'b0, rom_q_reg})
                                     : (MID + {1'b0, rom_q_reg});
      2'd1:    wave_next = idx2_reg[LUT_AW-1] ? '0 : '1;
      2'd2:    wave_next = saw_val;
      default: wave_next = tri_val;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wave_reg <= '0;
      v3_reg   <= 1'b0;
    end else begin
      wave_reg <= wave_next;
      v3_reg   <= v2_reg;
    end
  end

  assign wave_out   = wave_reg;
  assign wave_valid = v3_reg;
  assign wrap       = wrap_reg;

endmodule
